// File: rtl/weight_bpeb_loader.sv
// Loads a column-major stream of weights into per-slot registers and BPEB-encodes each one on the way in.
// Latency: the encoding is written on the same edge as the weight. done pulses one cycle after the last handshake.
// Backpressure: w_in_ready is high only in LOAD, and LOAD stalls for as long as w_in_valid stays low.
module weight_bpeb_loader #(
  parameter int num_pe_col   = 4,
  parameter int nb_taps      = 11,
  parameter int weight_width = 16,
  parameter int ETC_width    = 4
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            start,
  input  logic [3:0]                                      cfg_n_ap,
  input  logic [3:0]                                      cfg_kernel_size,
  input  logic                                            w_in_valid,
  output logic                                            w_in_ready,
  input  logic [weight_width-1:0]                         w_in_data,
  output logic [num_pe_col*nb_taps*weight_width-1:0]      WRegs,
  output logic [num_pe_col*nb_taps*3*(weight_width/2)-1:0] WBPRs,
  output logic [num_pe_col*nb_taps*ETC_width-1:0]         WETCs,
  output logic                                            busy,
  output logic                                            done,
  output logic                                            weights_valid
);
  localparam int G  = weight_width / 2;
  localparam int BW = 3 * G;
  localparam int CW = (num_pe_col > 1) ? $clog2(num_pe_col) : 1;
  localparam logic [3:0] TAPS4 = 4'((nb_taps > 15) ? 15 : nb_taps);

  typedef enum logic [1:0] {IDLE, CLEAR, LOAD, DONE} state_t;
  state_t state_q, state_d;

  logic [3:0]           k_q, n_ap_q, tap_q, k_sel;
  logic [CW-1:0]        col_q;
  logic                 hs, last_slot;
  logic [BW-1:0]        bpr_enc;
  logic [ETC_width-1:0] etc_enc;
  logic [weight_width:0] w_ext;

  assign k_sel     = (int'(cfg_kernel_size) > nb_taps) ? TAPS4 : cfg_kernel_size;
  assign hs        = w_in_valid && w_in_ready;
  assign last_slot = (col_q == CW'(num_pe_col - 1)) && (tap_q == k_q - 4'd1);

  assign busy       = (state_q == CLEAR) || (state_q == LOAD);
  assign w_in_ready = (state_q == LOAD);
  assign done       = (state_q == DONE);

  // Append a zero below bit 0 so each group is a plain 3-bit window.
  assign w_ext = {w_in_data, 1'b0};

  always_comb begin
    bpr_enc = '0;
    etc_enc = '0;
    for (int i = 0; i < G; i++) begin
      if (i >= int'(n_ap_q)) begin
        bpr_enc[3*i +: 3] = w_ext[2*i +: 3];
        if (w_ext[2*i +: 3] != 3'b000 && w_ext[2*i +: 3] != 3'b111)
          etc_enc = etc_enc + ETC_width'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CLEAR;
      CLEAR:   state_d = (k_q == 4'd0) ? DONE : LOAD;
      LOAD:    if (hs && last_slot) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q           <= '0;
      n_ap_q        <= '0;
      tap_q         <= '0;
      col_q         <= '0;
      WRegs         <= '0;
      WBPRs         <= '0;
      WETCs         <= '0;
      weights_valid <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            k_q           <= k_sel;
            n_ap_q        <= cfg_n_ap;
            weights_valid <= 1'b0;
          end
        end
        CLEAR: begin
          WRegs <= '0;
          WBPRs <= '0;
          WETCs <= '0;
          tap_q <= '0;
          col_q <= '0;
        end
        LOAD: begin
          if (hs) begin
            for (int c = 0; c < num_pe_col; c++) begin
              for (int t = 0; t < nb_taps; t++) begin
                if (int'(col_q) == c && int'(tap_q) == t) begin
                  WRegs[(c*nb_taps+t)*weight_width +: weight_width] <= w_in_data;
                  WBPRs[(c*nb_taps+t)*BW +: BW]                     <= bpr_enc;
                  WETCs[(c*nb_taps+t)*ETC_width +: ETC_width]       <= etc_enc;
                end
              end
            end
            if (tap_q == k_q - 4'd1) begin
              tap_q <= '0;
              col_q <= col_q + CW'(1);
            end else begin
              tap_q <= tap_q + 4'd1;
            end
          end
        end
        default: ;
      endcase
      if (state_d == DONE && state_q != DONE)
        weights_valid <= 1'b1;
    end
  end
endmodule

// File: tb/tb_weight_bpeb_loader.sv
// Bench for weight_bpeb_loader: an arithmetic slot model checked every cycle, plus literal encoding pins.
module tb_weight_bpeb_loader;
  localparam int NC = 4;
  localparam int NT = 11;
  localparam int WW = 16;
  localparam int EW = 4;
  localparam int BW = 24;
  localparam int NS = NC * NT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [3:0] cfg_n_ap = '0;
  logic [3:0] cfg_kernel_size = '0;
  logic w_in_valid = 1'b0;
  logic w_in_ready;
  logic [WW-1:0] w_in_data = '0;
  logic [NS*WW-1:0] WRegs;
  logic [NS*BW-1:0] WBPRs;
  logic [NS*EW-1:0] WETCs;
  logic busy, done, weights_valid;

  always #5 clk = ~clk;

  weight_bpeb_loader #(.num_pe_col(NC), .nb_taps(NT), .weight_width(WW), .ETC_width(EW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_n_ap(cfg_n_ap), .cfg_kernel_size(cfg_kernel_size),
    .w_in_valid(w_in_valid), .w_in_ready(w_in_ready), .w_in_data(w_in_data),
    .WRegs(WRegs), .WBPRs(WBPRs), .WETCs(WETCs),
    .busy(busy), .done(done), .weights_valid(weights_valid)
  );

  int total = 0;
  int bad = 0;
  logic chk_en = 1'b0;
  int done_cnt = 0;
  int rdy_cnt = 0;
  logic [WW-1:0] wq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] enc_bpr(input logic [WW-1:0] w, input int nap);
    logic [BW-1:0] r;
    r = '0;
    for (int i = 0; i < WW/2; i++) begin
      if (i >= nap) begin
        r[3*i+2] = w[2*i+1];
        r[3*i+1] = w[2*i];
        if (i > 0) r[3*i] = w[2*i-1];
      end
    end
    return r;
  endfunction

  function automatic logic [EW-1:0] enc_etc(input logic [WW-1:0] w, input int nap);
    logic [BW-1:0] r;
    int n;
    r = enc_bpr(w, nap);
    n = 0;
    for (int i = 0; i < WW/2; i++)
      if (r[3*i +: 3] != 3'b000 && r[3*i +: 3] != 3'b111) n++;
    return EW'(n);
  endfunction

  // Model: phase 0 idle, 1 clear, 2 load, 3 done; slots filled by arithmetic on the handshake count.
  int mphase, mk, mnap, mcount;
  logic mvalid;
  logic [NS*WW-1:0] mw;
  logic [NS*BW-1:0] mb;
  logic [NS*EW-1:0] me;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mphase <= 0; mk <= 0; mnap <= 0; mcount <= 0; mvalid <= 1'b0;
      mw <= '0; mb <= '0; me <= '0;
    end else begin
      case (mphase)
        0: if (start) begin
          mk     <= (int'(cfg_kernel_size) > NT) ? NT : int'(cfg_kernel_size);
          mnap   <= int'(cfg_n_ap);
          mvalid <= 1'b0;
          mphase <= 1;
        end
        1: begin
          mw <= '0; mb <= '0; me <= '0;
          mcount <= 0;
          mphase <= (mk == 0) ? 3 : 2;
          if (mk == 0) mvalid <= 1'b1;
        end
        2: if (w_in_valid) begin
          mw[((mcount / mk) * NT + mcount % mk) * WW +: WW] <= w_in_data;
          mb[((mcount / mk) * NT + mcount % mk) * BW +: BW] <= enc_bpr(w_in_data, mnap);
          me[((mcount / mk) * NT + mcount % mk) * EW +: EW] <= enc_etc(w_in_data, mnap);
          mcount <= mcount + 1;
          if (mcount + 1 == NC * mk) begin
            mphase <= 3;
            mvalid <= 1'b1;
          end
        end
        default: mphase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (w_in_ready) rdy_cnt <= rdy_cnt + 1;
    if (chk_en) begin
      chk("busy", 64'(busy), 64'(mphase == 1 || mphase == 2));
      chk("w_in_ready", 64'(w_in_ready), 64'(mphase == 2));
      chk("done", 64'(done), 64'(mphase == 3));
      chk("weights_valid", 64'(weights_valid), 64'(mvalid));
      total += 3;
      if (WRegs !== mw) begin bad++; $display("FAIL WRegs: got %h expected %h", WRegs, mw); end
      if (WBPRs !== mb) begin bad++; $display("FAIL WBPRs: got %h expected %h", WBPRs, mb); end
      if (WETCs !== me) begin bad++; $display("FAIL WETCs: got %h expected %h", WETCs, me); end
    end
  end

  function automatic logic [63:0] dut_w(input int c, input int t);
    return 64'(WRegs[(c*NT+t)*WW +: WW]);
  endfunction
  function automatic logic [63:0] dut_b(input int c, input int t);
    return 64'(WBPRs[(c*NT+t)*BW +: BW]);
  endfunction
  function automatic logic [63:0] dut_e(input int c, input int t);
    return 64'(WETCs[(c*NT+t)*EW +: EW]);
  endfunction

  // Drives a start, then nw weights from wq with random idle gaps; optional ignored start at index start_at.
  task automatic run_load(input logic [3:0] nap, input logic [3:0] ks, input int nw,
                          input int gap_max, input int start_at, input bit wait_done);
    int t;
    @(negedge clk);
    start = 1'b1; cfg_n_ap = nap; cfg_kernel_size = ks;
    @(negedge clk);
    start = 1'b0; cfg_n_ap = 4'($urandom); cfg_kernel_size = 4'($urandom);
    for (int i = 0; i < nw; i++) begin
      w_in_valid = 1'b0;
      w_in_data = WW'($urandom);
      repeat ($urandom_range(gap_max, 0)) @(negedge clk);
      w_in_valid = 1'b1;
      w_in_data = wq[i];
      start = (i == start_at);
      t = 0;
      while (!w_in_ready && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) chk("ready_timeout", 64'(w_in_ready), 64'(1));
      @(negedge clk);
    end
    w_in_valid = 1'b0;
    start = 1'b0;
    if (wait_done) begin
      t = 0;
      while (!done && t < 20) begin @(negedge clk); t++; end
      if (t >= 20) chk("done_timeout", 64'(done), 64'(1));
      repeat (2) @(negedge clk);
    end
  endtask

  int d0, r0;

  initial begin
    // Pin the model's encoder to hand-computed values.
    chk("enc_ffff_bpr", 64'(enc_bpr(16'hFFFF, 0)), 64'h00FFFFFE);
    chk("enc_ffff_etc", 64'(enc_etc(16'hFFFF, 0)), 64'd1);
    chk("enc_0001_bpr", 64'(enc_bpr(16'h0001, 0)), 64'h000002);
    chk("enc_5555_bpr", 64'(enc_bpr(16'h5555, 0)), 64'h492492);
    chk("enc_5555_etc", 64'(enc_etc(16'h5555, 0)), 64'd8);
    chk("enc_0005_nap1", 64'(enc_bpr(16'h0005, 1)), 64'h000010);

    #1;
    chk("rst_wregs_zero", 64'(|WRegs), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wvalid", 64'(weights_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // 4 cols x K=3 with gaps.
    wq = '{16'hFFFF, 16'h0001, 16'h5555, 16'h1234, 16'h8000, 16'h7FFF,
           16'hAAAA, 16'h0F0F, 16'hFFFE, 16'h0003, 16'hC001, 16'h4321};
    d0 = done_cnt;
    run_load(4'd0, 4'd3, 12, 3, -1, 1'b1);
    chk("k3_done_once", 64'(done_cnt - d0), 64'd1);
    chk("k3_wvalid", 64'(weights_valid), 64'd1);
    chk("s00_w", dut_w(0, 0), 64'hFFFF);
    chk("s00_bpr", dut_b(0, 0), 64'hFFFFFE);
    chk("s00_etc", dut_e(0, 0), 64'd1);
    chk("s01_bpr", dut_b(0, 1), 64'h000002);
    chk("s02_bpr", dut_b(0, 2), 64'h492492);
    chk("s02_etc", dut_e(0, 2), 64'd8);
    chk("s10_w", dut_w(1, 0), 64'h1234);
    chk("s03_zero", dut_w(0, 3), 64'd0);
    chk("s3a_zero", dut_w(3, 10), 64'd0);

    // n_ap=1, K=1.
    wq = '{16'h0005, 16'h0006, 16'h0007, 16'h0008};
    run_load(4'd1, 4'd1, 4, 1, -1, 1'b1);
    chk("nap1_bpr", dut_b(0, 0), 64'h000010);
    chk("nap1_etc", dut_e(0, 0), 64'd1);
    chk("nap1_s01_zero", dut_w(0, 1), 64'd0);

    // n_ap=9 abandons every group.
    run_load(4'd9, 4'd1, 4, 0, -1, 1'b1);
    chk("nap9_w", dut_w(0, 0), 64'h0005);
    chk("nap9_bpr", dut_b(0, 0), 64'd0);
    chk("nap9_etc", dut_e(0, 0), 64'd0);

    // Reset after the 5th handshake of a K=4 load.
    wq = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    run_load(4'd0, 4'd4, 5, 1, -1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wregs", 64'(|WRegs), 64'd0);
    chk("arst_wbprs", 64'(|WBPRs), 64'd0);
    chk("arst_wetcs", 64'(|WETCs), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_ready", 64'(w_in_ready), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_wvalid", 64'(weights_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // K=0: CLEAR straight to DONE, never ready.
    d0 = done_cnt;
    r0 = rdy_cnt;
    run_load(4'd0, 4'd0, 0, 0, -1, 1'b1);
    chk("k0_done_once", 64'(done_cnt - d0), 64'd1);
    chk("k0_no_ready", 64'(rdy_cnt - r0), 64'd0);
    chk("k0_wvalid", 64'(weights_valid), 64'd1);

    // cfg_kernel_size=15 clamps to 11; a start mid-LOAD is ignored.
    wq.delete();
    for (int i = 0; i < NC * NT; i++) wq.push_back(WW'(16'h0100 + i * 16'h0203));
    d0 = done_cnt;
    run_load(4'd2, 4'd15, NC * NT, 1, 10, 1'b1);
    chk("k15_done_once", 64'(done_cnt - d0), 64'd1);
    chk("k15_last_w", dut_w(3, 10), 64'(16'h0100 + 43 * 16'h0203));
    chk("k15_first_w", dut_w(0, 0), 64'h0100);
    repeat (3) @(negedge clk);
    chk("k15_idle", 64'(busy), 64'd0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/weight_bpeb_loader.md
WEIGHT_BPEB_LOADER -- requirements
Module: weight_bpeb_loader

Interface
REQ-001 Parameter num_pe_col, default 4: number of PE columns served.
REQ-002 Parameter nb_taps, default 11: weight slots per column.
REQ-003 Parameter weight_width, default 16: weight width, even, 4..16.
REQ-004 Parameter ETC_width, default 4: ETC width, at least clog2(G+1), where G = weight_width/2 and weight_bpr_width = 3*G.
REQ-005 clk  in  1: single clock; all state changes on its rising edge.
REQ-006 rst_n  in  1: reset, asynchronous, active-low.
REQ-007 start  in  1: one-cycle request to begin a load; sampled in IDLE only.
REQ-008 cfg_n_ap  in  4: approximation level; groups with index below it are abandoned; latched at start.
REQ-009 cfg_kernel_size  in  4: taps loaded per column; latched at start.
REQ-010 w_in_valid / w_in_ready  in / out  1 each: weight stream handshake.
REQ-011 w_in_data  in  weight_width: two's-complement weight.
REQ-012 WRegs  out  num_pe_col*nb_taps*weight_width: raw weights, slot [col][tap].
REQ-013 WBPRs  out  num_pe_col*nb_taps*weight_bpr_width: BPEB-encoded weights.
REQ-014 WETCs  out  num_pe_col*nb_taps*ETC_width: effective term count per slot.
REQ-015 busy  out  1: high in CLEAR and LOAD.
REQ-016 done  out  1: one-cycle pulse when the load completes.
REQ-017 weights_valid  out  1: WRegs, WBPRs and WETCs are complete and stable.

Function
REQ-018 The FSM states shall be IDLE, CLEAR, LOAD and DONE; each state lasts one cycle except LOAD.
- IDLE: on start, latch the configuration and go to CLEAR.
- CLEAR: zero every WRegs, WBPRs and WETCs slot, then go to LOAD, or to DONE if the effective kernel size K = 0.
- LOAD: stay until the last slot is written.
- DONE: go to IDLE.
REQ-019 K shall be min(cfg_kernel_size, nb_taps).
REQ-020 w_in_ready shall be high only in LOAD.
REQ-021 Each valid&&ready cycle shall write exactly one slot, in order col 0 tap 0..K-1, then col 1, and so on; throughput is one weight per cycle.
REQ-022 Tap and column counters shall advance only on a handshake; tap wraps from K-1 to 0 and increments col.
REQ-023 The handshake on slot [num_pe_col-1][K-1] shall move the FSM to DONE; done is high in DONE, one cycle after the last handshake.
REQ-024 Slots with tap >= K shall keep their CLEAR values (weight 0, BPR 0, ETC 0).
REQ-025 Encoding is combinational from w_in_data and is written on the same edge as the weight.
- For group i = 0..G-1 with i >= n_ap: BPR[3i+2:3i] = {w[2i+1], w[2i], w[2i-1]}, where w[-1] = 0.
- For i < n_ap: the group is 000.
REQ-026 ETC shall equal the number of groups whose 3-bit code is neither 000 nor 111; if n_ap >= G, BPR = 0 and ETC = 0.
REQ-027 weights_valid shall clear on the start edge and set on entry to DONE.
REQ-028 start while busy or in DONE shall be ignored.
REQ-029 w_in_valid outside LOAD shall have no effect.
REQ-030 w_in_data shall be ignored when w_in_valid is low; LOAD may stall indefinitely.

Reset
REQ-031 Asserting rst_n low, including mid-LOAD, shall immediately force IDLE and zero all counters and all outputs.
- Outputs zeroed: WRegs, WBPRs, WETCs, busy, done, w_in_ready, weights_valid.
REQ-032 After release, the block shall wait for a new start; there is no partial-load recovery.

Verification
REQ-033 Weight 0xFFFF, n_ap=0 -> slot BPR 0xFFFFFE, ETC 1, WRegs 0xFFFF.
REQ-034 Weights 0x0001 (n_ap=0) and 0x5555 (n_ap=0) -> BPR 0x000002/ETC 1 and BPR 0x492492/ETC 8 respectively.
REQ-035 Weight 0x0005, n_ap=1 -> BPR 0x000010, ETC 1; with n_ap=9 -> BPR 0, ETC 0.
REQ-036 4 cols, K=3, 12 weights with random valid gaps:
- slots filled column-major; taps 3..10 zero;
- done pulses exactly once, one cycle after the 12th handshake;
- weights_valid is high from DONE onward.
REQ-037 Reset asserted after the 5th handshake -> all outputs 0 and IDLE asynchronously.
- A following start with K=0 -> CLEAR, DONE, done pulse; no w_in_ready.
REQ-038 cfg_kernel_size=15 -> K=11, so 44 handshakes; a start issued during LOAD is ignored.
